// File: rtl/botao_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package botao_pkg;

  // Debounce FSM states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    HOLD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  // Defaults for a 50 MHz clock: 20 ms debounce, 0.3 s hold, repeat period
  localparam int DEBOUNCE_CYCLES_DEF = 32'd1000000;
  localparam int HOLD_CYCLES_DEF     = 32'd15000000;
  localparam int REPEAT_CYCLES_DEF   = 32'd5000000;
  localparam int CNT_W_DEF           = 32'd32;

endpackage

// File: rtl/botao_debouncer_if.sv
// Button conditioner bus: raw button in, debounced level and pulses out.
interface botao_debouncer_if;

  logic botao;          // raw button, active-low
  logic pressed;        // debounced level, 1 = held
  logic press_pulse;    // one cycle on accepted press
  logic release_pulse;  // one cycle on accepted release
  logic hold;           // long-press level
  logic repeat_pulse;   // hold entry and periodic auto-repeat

  modport master (
    output botao,
    input  pressed, press_pulse, release_pulse, hold, repeat_pulse
  );

  modport slave (
    input  botao,
    output pressed, press_pulse, release_pulse, hold, repeat_pulse
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r <= RST_VAL;
      s2_r <= RST_VAL;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/botao_debouncer.sv
// Push-button conditioner: synchronizer, counter-based debounce FSM,
// registered level output plus press/release/auto-repeat pulses.
module botao_debouncer
  import botao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  botao_debouncer_if.slave   bus
);

  // Terminal counts; the counter is cleared on every terminal count so it never wraps
  localparam logic [CNT_W-1:0] DEB_LAST_C  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST_C  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

  logic             sync_q_s;
  logic             b_s;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             from_hold_r, from_hold_nxt_s;
  logic             pressed_r, press_pulse_r, release_pulse_r, hold_r, repeat_pulse_r;
  logic             pressed_nxt_s, press_pulse_nxt_s, release_pulse_nxt_s;
  logic             hold_nxt_s, repeat_pulse_nxt_s;

  // Idle level of the button is high, so the synchronizer resets to 1
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.botao),
    .q     (sync_q_s)
  );

  assign b_s = ~sync_q_s;

  // State, counter and origin-flag register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO_C;
      from_hold_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      from_hold_r <= from_hold_nxt_s;
    end
  end

  // Next-state, counter and release-origin logic
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    from_hold_nxt_s = from_hold_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = CNT_ZERO_C;
        if (b_s) begin
          state_nxt_s = PRESS_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!b_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO_C;
        end else if (cnt_r == DEB_LAST_C) begin
          state_nxt_s = PRESSED;
          cnt_nxt_s   = CNT_ZERO_C;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE_C;
        end
      end
      PRESSED: begin
        if (!b_s) begin
          state_nxt_s     = RELEASE_WAIT;
          cnt_nxt_s       = CNT_ZERO_C;
          from_hold_nxt_s = 1'b0;
        end else if (cnt_r == HOLD_LAST_C) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = CNT_ZERO_C;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE_C;
        end
      end
      HOLD: begin
        if (!b_s) begin
          state_nxt_s     = RELEASE_WAIT;
          cnt_nxt_s       = CNT_ZERO_C;
          from_hold_nxt_s = 1'b1;
        end else if (cnt_r == REP_LAST_C) begin
          cnt_nxt_s = CNT_ZERO_C;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE_C;
        end
      end
      RELEASE_WAIT: begin
        if (b_s) begin
          // Bounce on release: resume where we came from with a fresh timer
          state_nxt_s = from_hold_r ? HOLD : PRESSED;
          cnt_nxt_s   = CNT_ZERO_C;
        end else if (cnt_r == DEB_LAST_C) begin
          state_nxt_s     = IDLE;
          cnt_nxt_s       = CNT_ZERO_C;
          from_hold_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE_C;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        cnt_nxt_s       = CNT_ZERO_C;
        from_hold_nxt_s = 1'b0;
      end
    endcase
  end

  // Output decode: levels follow the next state, pulses mark transitions
  always_comb begin
    pressed_nxt_s = 1'b0;
    hold_nxt_s    = 1'b0;
    case (state_nxt_s)
      IDLE:         begin pressed_nxt_s = 1'b0; hold_nxt_s = 1'b0;            end
      PRESS_WAIT:   begin pressed_nxt_s = 1'b0; hold_nxt_s = 1'b0;            end
      PRESSED:      begin pressed_nxt_s = 1'b1; hold_nxt_s = 1'b0;            end
      HOLD:         begin pressed_nxt_s = 1'b1; hold_nxt_s = 1'b1;            end
      RELEASE_WAIT: begin pressed_nxt_s = 1'b1; hold_nxt_s = from_hold_nxt_s; end
      default:      begin pressed_nxt_s = 1'b0; hold_nxt_s = 1'b0;            end
    endcase
    press_pulse_nxt_s   = (state_r == PRESS_WAIT)   && (state_nxt_s == PRESSED);
    release_pulse_nxt_s = (state_r == RELEASE_WAIT) && (state_nxt_s == IDLE);
    repeat_pulse_nxt_s  = ((state_r == PRESSED) && (state_nxt_s == HOLD)) ||
                          ((state_r == HOLD) && b_s && (cnt_r == REP_LAST_C));
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pressed_r       <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
      hold_r          <= 1'b0;
      repeat_pulse_r  <= 1'b0;
    end else begin
      pressed_r       <= pressed_nxt_s;
      press_pulse_r   <= press_pulse_nxt_s;
      release_pulse_r <= release_pulse_nxt_s;
      hold_r          <= hold_nxt_s;
      repeat_pulse_r  <= repeat_pulse_nxt_s;
    end
  end

  assign bus.pressed       = pressed_r;
  assign bus.press_pulse   = press_pulse_r;
  assign bus.release_pulse = release_pulse_r;
  assign bus.hold          = hold_r;
  assign bus.repeat_pulse  = repeat_pulse_r;

endmodule

// File: doc/botao_debouncer.md
Name: botao_debouncer

Overview:
Conditions the raw, active-low push-button input (botao) before it reaches the LED/state-stepping FSM. Pipeline: 2-flop synchronizer → counter-based debounce state machine. Outputs a clean active-high level plus single-cycle press, release and auto-repeat pulses, so the downstream FSM advances one step per pulse instead of free-running its own counter.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the input must be stable before a press or release is accepted (20 ms at 50 MHz); must be ≥2.
- HOLD_CYCLES, 15000000, cycles of continuous accepted press before hold asserts (0.3 s at 50 MHz); must be ≥2.
- REPEAT_CYCLES, 5000000, auto-repeat period while in hold; must be ≥2.
- CNT_W, 32, width of the shared cycle counter; must hold the largest of the three counts.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- botao  in  1  raw button, asynchronous, active-low (0 = pressed)
- pressed  out  1  debounced level, 1 = button held
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on accepted release
- hold  out  1  high while press has lasted ≥ HOLD_CYCLES
- repeat_pulse  out  1  one-cycle pulse at hold entry and every REPEAT_CYCLES afterwards

Behaviour:
- Single clock domain (clock); reset synchronous, active-high, highest priority, may arrive at any cycle.
- Reset values: sync flops = 1 (released), state = IDLE, cnt = 0, all outputs = 0.
- Synchronizer: s1 <= botao; s2 <= s1; b = ~s2 (1 = pressed). The FSM uses only b.
- All outputs are registered. Pulses are exactly one cycle wide.
- IDLE: pressed=0, hold=0. b=1 → PRESS_WAIT, cnt=0.
- PRESS_WAIT: b=0 → IDLE (bounce rejected, no pulse). Otherwise cnt++. cnt==DEBOUNCE_CYCLES-1 → PRESSED, cnt=0, press_pulse=1, pressed=1.
- PRESSED: b=0 → RELEASE_WAIT, cnt=0. Otherwise cnt++. cnt==HOLD_CYCLES-1 → HOLD, cnt=0, hold=1, repeat_pulse=1.
- HOLD: b=0 → RELEASE_WAIT, cnt=0. Otherwise cnt++. cnt==REPEAT_CYCLES-1 → repeat_pulse=1, cnt=0.
- RELEASE_WAIT: pressed stays 1; hold keeps its value.
  - b=1 → return to the origin state (PRESSED or HOLD, tracked by a 1-bit flag), cnt=0. No pulse. The hold timer restarts from 0 on return to PRESSED.
  - Otherwise cnt++. cnt==DEBOUNCE_CYCLES-1 → IDLE, pressed=0, hold=0, release_pulse=1.
- Latency:
  - botao first sampled 0 at edge t, held low: press_pulse high in the cycle after edge t+DEBOUNCE_CYCLES+2.
  - Release latency is identical and measured to release_pulse.
- Counter never wraps: every state resets cnt on exit or terminal count.
- press_pulse and release_pulse are never high in the same cycle. repeat_pulse never coincides with press_pulse.
- Reset during any state (including mid-HOLD): next cycle IDLE, all outputs 0. No release_pulse is emitted.
- botao held low through reset deassertion is treated as a fresh press: full debounce, then press_pulse.

Decomposition:
- Package botao_pkg:
  - state enum {IDLE, PRESS_WAIT, PRESSED, HOLD, RELEASE_WAIT} (3 bits)
  - default constants for DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES, CNT_W.
- One sub-module: sync_2ff (parameterizable reset value; resets to 1 here), reusable for the other vending-machine buttons.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Clean press: botao 1→0 at edge 10, held 8 cycles, then 1 → press_pulse single cycle after edge 16; pressed=1 from then; release_pulse single cycle 6 edges after botao returns to 1; pressed=0 with it.
- Bounce on press: botao low 2 cycles, high 1, low 2, high → no pulses, pressed stays 0, state back to IDLE.
- Bounce on release: accepted press, then botao high 2 cycles and low again → no release_pulse, pressed stays 1, hold timer restarts at 0.
- Hold/repeat: botao low 40 cycles → press_pulse once; hold and first repeat_pulse 10 cycles after press_pulse; further repeat_pulse every 3 cycles; release → release_pulse, hold drops with it.
- Reset mid-HOLD: assert reset 1 cycle while in HOLD, botao still low → next cycle all outputs 0, no release_pulse; press_pulse again 4+3 cycles later.
- Width/wrap check: CNT_W=4, HOLD_CYCLES=15, REPEAT_CYCLES=15, held 60 cycles → repeat_pulse spacing exactly 15, no spurious pulse from counter wrap.
